// File: rtl/keypad_entry_ctrl.sv
// Matrix keypad scanner with frame-based press/release debounce and a digit
// entry buffer; ENTER counts attempts, CLEAR empties the buffer.
module keypad_entry_ctrl #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_FRAMES = 4,
  parameter int ENTER_CODE = 15,
  parameter int CLEAR_CODE = 14
) (
  input  logic                  clk_50M,
  input  logic                  RSTn,
  input  logic [COLS-1:0]       col,
  output logic [ROWS-1:0]       row,
  output logic [3:0]            key_code,
  output logic                  key_valid,
  output logic [4*DIGITS-1:0]   entry,
  output logic [3:0]            digit_cnt,
  output logic                  enter_pulse,
  output logic [7:0]            tries
);

  localparam int                ENTRY_W    = 4 * DIGITS;
  localparam int                DIV_W      = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0]  DWELL_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [1:0]        ROW_LAST   = 2'(ROWS - 1);
  localparam logic [3:0]        DEB_TARGET = 4'(DEB_FRAMES);
  localparam logic [3:0]        COLS_C     = 4'(COLS);
  localparam logic [3:0]        DIGITS_C   = 4'(DIGITS);
  localparam logic [3:0]        ENTER_C    = 4'(ENTER_CODE);
  localparam logic [3:0]        CLEAR_C    = 4'(CLEAR_CODE);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PRESS_DEB = 2'd1;
  localparam logic [1:0] HELD      = 2'd2;
  localparam logic [1:0] REL_DEB   = 2'd3;

  logic [DIV_W-1:0] dwell_cnt;
  logic [1:0]       row_idx;
  logic [1:0]       acc_hits;   // keys seen so far this frame, saturated at 2
  logic [3:0]       acc_code;
  logic [1:0]       state, state_n;
  logic [3:0]       deb_cnt, deb_n;
  logic [3:0]       cand, cand_n;

  logic             sample, frame_end, accept;
  logic [2:0]       row_hits, frame_hits;
  logic [1:0]       row_col;
  logic [3:0]       row_code, frame_code;
  logic             res_none, res_single;

  assign sample    = (dwell_cnt == DWELL_LAST);
  assign frame_end = sample && (row_idx == ROW_LAST);

  // NOTE: every variable gets a default at the top of a combinational block,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    row_hits = 3'd0;
    row_col  = 2'd0;
    for (int c = 0; c < COLS; c++) begin
      if (!col[c]) begin
        row_hits = row_hits + 3'd1;
        row_col  = 2'(c);
      end
    end
  end

  assign row_code   = 4'(row_idx) * COLS_C + 4'(row_col);
  assign frame_hits = {1'b0, acc_hits} + row_hits;
  assign frame_code = (row_hits == 3'd1) ? row_code : acc_code;
  assign res_none   = (frame_hits == 3'd0);
  assign res_single = (frame_hits == 3'd1);

  // Debounce decisions happen only on the frame-end sample cycle.
  always_comb begin
    state_n = state;
    deb_n   = deb_cnt;
    cand_n  = cand;
    accept  = 1'b0;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (res_single) begin
            cand_n = frame_code;
            deb_n  = 4'd1;
            if (DEB_FRAMES == 1) begin
              accept  = 1'b1;
              state_n = HELD;
            end else begin
              state_n = PRESS_DEB;
            end
          end
        end
        PRESS_DEB: begin
          if (res_single && frame_code == cand) begin
            deb_n = deb_cnt + 4'd1;
            if (deb_cnt + 4'd1 == DEB_TARGET) begin
              accept  = 1'b1;
              state_n = HELD;
            end
          end else begin
            state_n = IDLE;
          end
        end
        HELD: begin
          if (res_none) begin
            deb_n   = 4'd1;
            state_n = (DEB_FRAMES == 1) ? IDLE : REL_DEB;
          end
        end
        default: begin
          if (res_none) begin
            deb_n = deb_cnt + 4'd1;
            if (deb_cnt + 4'd1 == DEB_TARGET) state_n = IDLE;
          end else begin
            state_n = HELD;
          end
        end
      endcase
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_50M) begin
    if (!RSTn) begin
      dwell_cnt   <= '0;
      row_idx     <= 2'd0;
      row         <= {{(ROWS-1){1'b1}}, 1'b0};
      acc_hits    <= 2'd0;
      acc_code    <= 4'd0;
      state       <= IDLE;
      deb_cnt     <= 4'd0;
      cand        <= 4'd0;
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      enter_pulse <= 1'b0;
      entry       <= '0;
      digit_cnt   <= 4'd0;
      tries       <= 8'd0;
    end else begin
      state       <= state_n;
      deb_cnt     <= deb_n;
      cand        <= cand_n;
      key_valid   <= 1'b0;
      enter_pulse <= 1'b0;

      if (sample) begin
        dwell_cnt <= '0;
        row       <= {row[ROWS-2:0], row[ROWS-1]};
        if (frame_end) begin
          row_idx  <= 2'd0;
          acc_hits <= 2'd0;
          acc_code <= 4'd0;
        end else begin
          row_idx  <= row_idx + 2'd1;
          acc_hits <= (frame_hits >= 3'd2) ? 2'd2 : frame_hits[1:0];
          acc_code <= frame_code;
        end
      end else begin
        dwell_cnt <= dwell_cnt + DIV_W'(1);
      end

      // ENTER is tested first so it wins if both command codes coincide.
      if (accept) begin
        key_valid <= 1'b1;
        key_code  <= frame_code;
        if (frame_code == ENTER_C) begin
          enter_pulse <= 1'b1;
          if (tries != 8'hFF) tries <= tries + 8'd1;
        end else if (frame_code == CLEAR_C) begin
          entry     <= '0;
          digit_cnt <= 4'd0;
        end else begin
          entry <= (entry << 4) | ENTRY_W'(frame_code);
          if (digit_cnt != DIGITS_C) digit_cnt <= digit_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Keypad entry controller bench: a key-matrix model drives the columns and a
// frame-level reference model predicts every output on every cycle.
module tb_keypad_entry_ctrl;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int ENTER    = 15;
  localparam int CLEAR    = 14;
  localparam int FRAME    = ROWS * SCAN_DIV;

  logic                clk_50M = 1'b0;
  logic                RSTn    = 1'b0;
  logic [COLS-1:0]     col;
  logic [ROWS-1:0]     row;
  logic [3:0]          key_code;
  logic                key_valid;
  logic [4*DIGITS-1:0] entry;
  logic [3:0]          digit_cnt;
  logic                enter_pulse;
  logic [7:0]          tries;

  keypad_entry_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV),
    .DEB_FRAMES(DEB), .ENTER_CODE(ENTER), .CLEAR_CODE(CLEAR)
  ) dut (
    .clk_50M(clk_50M), .RSTn(RSTn), .col(col), .row(row),
    .key_code(key_code), .key_valid(key_valid), .entry(entry),
    .digit_cnt(digit_cnt), .enter_pulse(enter_pulse), .tries(tries)
  );

  always #10 clk_50M = ~clk_50M;

  // Pressed keys short their row line to their column line.
  logic [15:0] keys = 16'h0000;
  always_comb begin
    col = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!row[r] && keys[r*COLS+c]) col[c] = 1'b0;
  end

  int n_asserts  = 0;
  int n_fail     = 0;
  int kv_seen    = 0;
  int enter_seen = 0;
  int base;

  // Reference model state: run lengths of matching frames.
  logic        locked;
  int          run_len, none_run;
  int          run_key;
  logic        exp_valid, exp_enter;
  logic [3:0]  exp_code;
  logic [15:0] exp_entry;
  int          exp_cnt, exp_tries;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    locked = 1'b0; run_len = 0; none_run = 0; run_key = 0;
    exp_valid = 1'b0; exp_enter = 1'b0; exp_code = 4'd0;
    exp_entry = 16'h0; exp_cnt = 0; exp_tries = 0;
  endtask

  task automatic model_frame(input logic [15:0] k);
    int n;
    int code;
    n = $countones(k);
    code = 0;
    for (int b = 0; b < 16; b++) if (k[b]) code = b;
    exp_valid = 1'b0;
    exp_enter = 1'b0;
    if (!locked) begin
      if (n == 1 && run_len > 0 && code == run_key) run_len++;
      else if (n == 1 && run_len == 0) begin run_key = code; run_len = 1; end
      else run_len = 0;
      if (run_len == DEB) begin
        locked = 1'b1; none_run = 0; run_len = 0;
        exp_valid = 1'b1;
        exp_code  = 4'(code);
        if (code == ENTER) begin
          exp_enter = 1'b1;
          if (exp_tries < 255) exp_tries++;
        end else if (code == CLEAR) begin
          exp_entry = 16'h0; exp_cnt = 0;
        end else begin
          exp_entry = {exp_entry[11:0], 4'(code)};
          if (exp_cnt < DIGITS) exp_cnt++;
        end
      end
    end else begin
      if (n == 0) none_run++; else none_run = 0;
      if (none_run == DEB) begin locked = 1'b0; run_len = 0; end
    end
  endtask

  // Compare all outputs at a negedge; pos is edges since the frame started.
  task automatic check_cycle(input int pos);
    logic [3:0] exp_row;
    exp_row = ~(4'b0001 << ((pos / SCAN_DIV) % ROWS));
    if (key_valid === 1'b1) kv_seen++;
    if (enter_pulse === 1'b1) enter_seen++;
    check("row", 32'(row), 32'(exp_row));
    check("key_valid", 32'(key_valid), 32'(exp_valid));
    check("enter_pulse", 32'(enter_pulse), 32'(exp_enter));
    check("key_code", 32'(key_code), 32'(exp_code));
    check("entry", 32'(entry), 32'(exp_entry));
    check("digit_cnt", 32'(digit_cnt), 32'(exp_cnt));
    check("tries", 32'(tries), 32'(exp_tries));
  endtask

  task automatic run_frame(input logic [15:0] k);
    keys = k;
    for (int i = 1; i <= FRAME; i++) begin
      @(negedge clk_50M);
      if (i == FRAME) model_frame(k);
      else begin exp_valid = 1'b0; exp_enter = 1'b0; end
      check_cycle(i);
    end
  endtask

  task automatic press(input int k);
    run_frame(16'(1) << k);
    run_frame(16'(1) << k);
    run_frame(16'h0);
    run_frame(16'h0);
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk_50M);
      check_cycle(0);
    end
    RSTn = 1'b1;
  endtask

  initial begin
    logic [15:0] rk;
    int          r;
    do_reset();

    // Key 5 held three frames: single accept.
    base = kv_seen;
    repeat (3) run_frame(16'(1) << 5);
    check("hold5_pulses", 32'(kv_seen - base), 32'd1);
    check("hold5_code", 32'(key_code), 32'd5);
    check("hold5_entry_lsd", 32'(entry[3:0]), 32'd5);
    check("hold5_cnt", 32'(digit_cnt), 32'd1);
    run_frame(16'h0);
    run_frame(16'h0);

    // Six presses overflow a four-digit buffer.
    press(1); press(2); press(3); press(4); press(6);
    check("seq_entry", 32'(entry), 32'h2346);
    check("seq_cnt", 32'(digit_cnt), 32'd4);

    // Bouncing key 7 never accepted.
    base = kv_seen;
    repeat (3) begin
      run_frame(16'(1) << 7);
      run_frame(16'h0);
    end
    check("bounce_pulses", 32'(kv_seen - base), 32'd0);

    // Two keys together are ignored; the survivor is then accepted once.
    base = kv_seen;
    repeat (5) run_frame((16'(1) << 2) | (16'(1) << 9));
    check("multi_pulses", 32'(kv_seen - base), 32'd0);
    repeat (3) run_frame(16'(1) << 2);
    check("multi_then2_pulses", 32'(kv_seen - base), 32'd1);
    check("multi_then2_code", 32'(key_code), 32'd2);
    run_frame(16'h0);
    run_frame(16'h0);

    // Random key activity with sticky holds so some presses debounce.
    for (int f = 0; f < 80; f++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3) rk = 16'h0;
      else if (r < 9) rk = 16'(1) << $urandom_range(0, 15);
      else begin
        rk = 16'($urandom);
        if ($countones(rk) < 2) rk = 16'h0101;
      end
      repeat ($urandom_range(1, 3)) run_frame(rk);
    end
    run_frame(16'h0);
    run_frame(16'h0);

    // ENTER 256 times saturates tries; CLEAR empties the buffer only.
    base = enter_seen;
    repeat (256) press(ENTER);
    check("enter_pulses", 32'(enter_seen - base), 32'd256);
    check("tries_sat", 32'(tries), 32'd255);
    press(CLEAR);
    check("clear_entry", 32'(entry), 32'd0);
    check("clear_cnt", 32'(digit_cnt), 32'd0);
    check("clear_tries", 32'(tries), 32'd255);
    check("clear_code", 32'(key_code), 32'(CLEAR));

    // Reset during press debounce of key 3 while the key stays down.
    press(8);
    run_frame(16'(1) << 3);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk_50M);
      exp_valid = 1'b0; exp_enter = 1'b0;
      check_cycle(i);
    end
    do_reset();
    base = kv_seen;
    run_frame(16'(1) << 3);
    check("rst_no_early_accept", 32'(kv_seen - base), 32'd0);
    run_frame(16'(1) << 3);
    check("rst_accept_pulses", 32'(kv_seen - base), 32'd1);
    check("rst_accept_code", 32'(key_code), 32'd3);
    check("rst_accept_cnt", 32'(digit_cnt), 32'd1);
    run_frame(16'h0);
    run_frame(16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_entry_ctrl.md
KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 4: keypad row count, 2..4.
REQ-002 SHALL have parameter COLS, default 4: keypad column count, 2..4.
REQ-003 SHALL have parameter DIGITS, default 4: entry buffer depth in 4-bit digits, 1..8.
REQ-004 SHALL have parameter SCAN_DIV, default 50000: clock cycles per row dwell, >=4.
REQ-005 SHALL have parameter DEB_FRAMES, default 4: consecutive full scan frames needed to accept a press or release, 1..15.
REQ-006 SHALL have parameters ENTER_CODE (default 15) and CLEAR_CODE (default 14): key codes with command meaning.
REQ-007 SHALL have port clk_50M, input, 1: sole clock.
REQ-008 SHALL have port RSTn, input, 1: reset, synchronous, active-low.
REQ-009 SHALL have port col, input, COLS: column sense, active-low, pre-synchronised externally.
REQ-010 SHALL have port row, output, ROWS: row drive, active-low one-hot.
REQ-011 SHALL have port key_code, output, 4: code of the last accepted key.
REQ-012 SHALL have port key_valid, output, 1: one-cycle pulse on each accepted press.
REQ-013 SHALL have port entry, output, 4*DIGITS: digit buffer, newest digit in bits [3:0].
REQ-014 SHALL have port digit_cnt, output, 4: number of digits held, 0..DIGITS.
REQ-015 SHALL have port enter_pulse, output, 1: one-cycle pulse when ENTER is accepted.
REQ-016 SHALL have port tries, output, 8: count of ENTER presses, saturating at 255.

Function
REQ-017 Key code SHALL be r*COLS+c for row r, column c (0-based); ROWS*COLS SHALL be <=16.
REQ-018 Scanner SHALL drive one row low for SCAN_DIV cycles, then advance to the next row, wrapping from ROWS-1 to 0.
REQ-019 col SHALL be sampled on the last dwell cycle of each row; one frame equals ROWS dwells.
REQ-020 At frame end, the frame result SHALL be NONE (no column low), SINGLE(code) (exactly one key low), or MULTI (two or more keys low).
REQ-021 Debounce FSM SHALL use states IDLE, PRESS_DEB, HELD, REL_DEB, updated only at frame end.
REQ-022 IDLE: SINGLE(k) -> PRESS_DEB with candidate k and count 1; when DEB_FRAMES=1, SHALL go directly to accept.
REQ-023 PRESS_DEB: SINGLE(same k) increments count, and reaching DEB_FRAMES accepts k and moves to HELD; any other result returns to IDLE.
REQ-024 HELD: NONE -> REL_DEB with count 1; SINGLE or MULTI stays in HELD; no auto-repeat.
REQ-025 REL_DEB: NONE increments count, and reaching DEB_FRAMES moves to IDLE; any key returns to HELD.
REQ-026 MULTI SHALL never produce an accept.
REQ-027 On accept, key_code SHALL update and key_valid SHALL pulse in the cycle after the frame-end sample.
REQ-028 Digit accept (not ENTER or CLEAR): entry SHALL shift left 4 bits with the new code in [3:0], and digit_cnt SHALL increment, saturating at DIGITS; the oldest digit is discarded when full.
REQ-029 CLEAR accept: entry and digit_cnt SHALL be set to 0 in the same cycle as key_valid; tries is unchanged.
REQ-030 ENTER accept: enter_pulse SHALL be asserted together with key_valid, tries SHALL increment unless at 255, and entry/digit_cnt SHALL be held unchanged.
REQ-031 When ENTER_CODE equals CLEAR_CODE, ENTER behaviour SHALL take precedence.

Reset
REQ-032 While RSTn=0 at a clock edge: row SHALL be all-ones except bit0=0, the dwell counter 0, the FSM IDLE, and key_code, entry, digit_cnt, tries, key_valid and enter_pulse all 0.
REQ-033 Reset asserted mid-debounce or mid-pulse SHALL abort the operation, with no accept generated after release.
REQ-034 After RSTn rises, scanning SHALL restart from row 0 with a full dwell.

Verification
REQ-035 Parameters SCAN_DIV=4, DEB_FRAMES=2; hold key 5 (r1,c1) for 3 frames -> exactly one key_valid, key_code=5, entry[3:0]=5, digit_cnt=1.
REQ-036 Press keys 1,2,3,4,6 with DIGITS=4, releasing between each -> entry=16'h2346, digit_cnt=4.
REQ-037 Bounce: key 7 present 1 frame, absent 1 frame, repeated for 6 frames -> no key_valid.
REQ-038 Keys 2 and 9 held together for 5 frames -> no accept; release 9 and hold 2 -> key 2 accepted once.
REQ-039 Press ENTER 256 times with release between -> 256 enter_pulses, tries=255; then CLEAR -> entry=0, digit_cnt=0, tries=255.
REQ-040 Assert RSTn=0 during PRESS_DEB of key 3, release it while still holding the key -> all outputs 0, key 3 accepted DEB_FRAMES frames after reset release.
